// File: rtl/uart_tx_stream.sv
// UART serial transmitter fed by a small word FIFO with a valid/ready push port.
// Framing (data width, parity, stop bits, inter-frame idle time) is fixed at elaboration.
module uart_tx_stream #(
  parameter int CLOCK_HZ  = 50_000_000,
  parameter int BAUD_RATE = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int IDLE_BITS = 0,
  parameter int DEPTH     = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_BITS-1:0]       in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic                       tx,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic                       frame_done
);
  localparam int CLKS_PER_BIT = CLOCK_HZ / BAUD_RATE;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int PTR_W        = $clog2(DEPTH);
  localparam int CW           = $clog2(DEPTH + 1);

  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic [3:0]       GAP_LAST  = 4'(IDLE_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_GAP
  } state_t;

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_reg;
  logic [PTR_W-1:0]     rd_ptr_reg;
  logic [CW-1:0]        count_reg;
  logic                 push;
  logic                 pop;

  state_t               state_reg, state_next;
  logic [CNT_W-1:0]     baud_reg, baud_next;
  logic [3:0]           bit_reg, bit_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic                 parity_reg, parity_next;
  logic                 tx_reg, tx_next;
  logic                 bit_end;

  assign in_ready   = !rst && (count_reg < CW'(DEPTH));
  assign push       = in_valid && in_ready;
  assign pop        = (state_reg == S_IDLE) && (count_reg != '0);
  assign fifo_count = count_reg;
  assign tx         = tx_reg;
  assign busy       = (state_reg != S_IDLE) || (count_reg != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= in_data;
    end
  end

  // Pointers are exactly log2(DEPTH) wide, so they wrap without explicit compare.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // The FIFO read is registered straight into the shift register on pop.
  always_ff @(posedge clk) begin
    if (pop) begin
      shift_reg <= mem[rd_ptr_reg];
    end else begin
      shift_reg <= shift_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= S_IDLE;
      baud_reg   <= '0;
      bit_reg    <= '0;
      parity_reg <= 1'b0;
      tx_reg     <= 1'b1;
    end else begin
      state_reg  <= state_next;
      baud_reg   <= baud_next;
      bit_reg    <= bit_next;
      parity_reg <= parity_next;
      tx_reg     <= tx_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    baud_next   = baud_reg;
    bit_next    = bit_reg;
    shift_next  = shift_reg;
    parity_next = parity_reg;
    tx_next     = tx_reg;
    frame_done  = 1'b0;
    bit_end     = (baud_reg == BAUD_LAST);

    if (state_reg != S_IDLE) begin
      baud_next = bit_end ? '0 : baud_reg + 1'b1;
    end

    case (state_reg)
      S_IDLE: begin
        tx_next = 1'b1;
        if (count_reg != '0) begin
          tx_next     = 1'b0;
          state_next  = S_START;
          baud_next   = '0;
          bit_next    = '0;
          // Odd parity starts the running XOR at 1.
          parity_next = (PARITY == 2);
        end
      end
      S_START: begin
        if (bit_end) begin
          tx_next    = shift_reg[0];
          state_next = S_DATA;
          bit_next   = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          parity_next = parity_reg ^ shift_reg[0];
          shift_next  = shift_reg >> 1;
          if (bit_reg == DATA_LAST) begin
            bit_next = '0;
            if (PARITY != 0) begin
              state_next = S_PARITY;
              tx_next    = parity_reg ^ shift_reg[0];
            end else begin
              state_next = S_STOP;
              tx_next    = 1'b1;
            end
          end else begin
            bit_next = bit_reg + 1'b1;
            tx_next  = shift_reg[1];
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_next = S_STOP;
          tx_next    = 1'b1;
          bit_next   = '0;
        end
      end
      S_STOP: begin
        tx_next = 1'b1;
        if (bit_end) begin
          if (bit_reg == STOP_LAST) begin
            frame_done = 1'b1;
            bit_next   = '0;
            state_next = (IDLE_BITS > 0) ? S_GAP : S_IDLE;
          end else begin
            bit_next = bit_reg + 1'b1;
          end
        end
      end
      S_GAP: begin
        tx_next = 1'b1;
        if (bit_end) begin
          if (bit_reg == GAP_LAST) begin
            bit_next   = '0;
            state_next = S_IDLE;
          end else begin
            bit_next = bit_reg + 1'b1;
          end
        end
      end
      default: begin
        state_next = S_IDLE;
        tx_next    = 1'b1;
      end
    endcase
  end

endmodule
